hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the five-stage MIPS pipeline. It decodes the D-stage instruction, covering the extended P6 instruction set, into read/write/Tuse/Tnew records. Internally it pipelines those records through E, M and W, and a counter models the multi-cycle multiply/divide unit. From that state it produces the D-stage stall and all forwarding-mux selects, and sits beside the D/E/M/W pipeline registers in the CPU top.

## Interface
- `MULT_CYCLES`, 5, busy cycles after a mult/multu enters E
- `DIV_CYCLES`, 10, busy cycles after a div/divu enters E
- `REG_AW`, 5, register-address width; register 0 is never a hazard source
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  reset; one clock, synchronous, active-low
- `ins_d`  in  32  instruction currently in D
- `stall`  out  1  hold PC and F/D register, insert bubble into E
- `fwd_rs_d`, `fwd_rt_d`  out  2  D compare/jr operand: 0 regfile, 1 from E, 2 from M
- `fwd_rs_e`, `fwd_rt_e`  out  2  ALU/MDU operand: 0 pipeline value, 1 from M, 2 from W
- `fwd_rt_m`  out  2  store data: 0 pipeline value, 1 from W
- `mdu_busy`  out  1  multiply/divide unit busy counter non-zero

## Operation
- Decode classes for `ins_d`:
  - cal_r: add, sub, and, or, slt, sltu.
  - cal_i: addi, andi, ori, lui.
  - load: lw, lh, lb.
  - store: sw, sh, sb.
  - branch: beq, bne.
  - Others: jal, jr, md (mult, multu, div, divu), mf (mfhi, mflo), mt (mthi, mtlo).
  - Any other encoding, including 0x00000000, decodes as a bubble: no reads, no write.
- Tuse for rs:
  - 0 for branch and jr.
  - 1 for cal_r, cal_i, load, store, md and mt.
- Tuse for rt:
  - 0 for branch.
  - 1 for cal_r and md.
  - 2 for store.
- Destination and Tnew at entry to E:
  - cal_r → rd, Tnew 1.
  - cal_i and load → rt; Tnew 1 for cal_i, 2 for load.
  - mf → rd, Tnew 1.
  - jal → 31, Tnew 0.
  - Destination 0 clears the write flag.
- Record = {write flag, destination, Tnew, md-start flag}. Each cycle:
  - E ← D record, or bubble if `stall`.
  - M ← E record with Tnew decremented; saturates at 0.
  - W ← M record with Tnew decremented; saturates at 0.
- `stall` = 1 if any of the following holds:
  - D reads rs (rs≠0), stage X ∈ {E, M} writes rs, and Tnew_X > Tuse_rs.
  - The same condition for rt.
  - D is md/mf/mt and (`mdu_busy` or the E record is an md start).
- Forward select rule:
  - A stage qualifies only if it writes, its destination is ≠ 0 and equals the source, and its Tnew = 0.
  - The nearest qualifying stage wins.
  - No qualifying stage gives select 0.
- MDU counter:
  - When the E record has md-start, the counter loads `MULT_CYCLES` (mult/multu) or `DIV_CYCLES` (div/divu) on the next edge.
  - Otherwise it decrements when non-zero.
  - `mdu_busy` = counter ≠ 0.
- Counter width = clog2(max(`MULT_CYCLES`, `DIV_CYCLES`) + 1).

## Timing
- Reset (`reset`=0 at an edge): E/M/W records become bubbles and the counter becomes 0. With `ins_d` = 0, `stall`, `mdu_busy` and all `fwd_*` read 0 the cycle after.
- `stall` and all `fwd_*` are combinational from `ins_d` and registered state, valid in the same cycle; state changes only at edges.
- A load followed immediately by a dependent cal_r: `stall` for 1 cycle.
- A load followed immediately by a dependent beq: `stall` for 2 cycles.
- A cal_r followed immediately by a dependent beq: `stall` for 1 cycle, then `fwd_*_d`=2.
- Once md enters E, `mdu_busy` rises the next cycle and stays high exactly N cycles. A following mf stalls for N+1 cycles total: one cycle while md sits in E, then N busy cycles.
- `reset` asserted while the counter is mid-count clears it at that edge; the stall drops the same cycle.
- Simultaneous stall and md in E: the md proceeds and the counter loads. The bubble enters E.

## Test plan
- `reset`=0 for 2 cycles, then `ins_d`=0 → `stall`=0, `mdu_busy`=0, all `fwd_*`=0.
- lw $1 → add $2,$1,$3 → `stall`=1 one cycle. Next cycle `stall`=0 and `fwd_rs_e`=2 once the add is in E.
- ori $1 → beq $1,$0 → `stall`=1 one cycle, then `fwd_rs_d`=2. jal → jr $31: no stall, `fwd_rs_d`=1.
- add $0,$1,$2 → add $3,$0,$0: no stall, all forwards 0.
- mult $1,$2 → mflo $3 with `MULT_CYCLES`=5 → `stall`=1 for 6 cycles and `mdu_busy` high 5 cycles. Repeat with div and `DIV_CYCLES`=10 → 11 stall cycles.
- Start div, assert `reset` on the 3rd busy cycle → the next cycle `mdu_busy`=0 and `stall`=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the five-stage MIPS pipeline: decodes the D-stage instruction, tracks
// E/M/W write records plus the MDU busy counter, and drives the D stall and forward selects.
module hazard_scoreboard #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned REG_AW      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic [1:0]  fwd_rt_m,
  output logic        mdu_busy
);
  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef logic [REG_AW-1:0] reg_t;
  typedef struct packed {
    logic       wr;
    reg_t       dst;
    logic [1:0] tnew;
    logic       md;
    logic       md_div;
  } rec_t;

  rec_t            r_rec_e, r_rec_m, r_rec_w;
  reg_t            r_rs_e, r_rt_e, r_st_e, r_st_m;
  logic [CntW-1:0] r_mdu_cnt;

  logic [5:0] w_op, w_fn;
  reg_t       w_rs, w_rt, w_rd;
  logic       w_cal_r, w_cal_i, w_load, w_store, w_branch;
  logic       w_jal, w_jr, w_md, w_mf, w_mt, w_div;
  logic [1:0] w_tuse_rs, w_tuse_rt;
  reg_t       w_src_rs, w_src_rt, w_src_st;
  rec_t       w_rec_d;
  logic       w_unused;

  assign w_unused = ^{ins_d[10:6], r_rec_w.md, r_rec_w.md_div};

  function automatic logic hazard(reg_t src, logic [1:0] tuse, rec_t rec);
    return rec.wr && (rec.dst == src) && (rec.tnew > tuse);
  endfunction

  // A write record never carries destination 0, so an unread source (0) never matches.
  function automatic logic ready(reg_t src, rec_t rec);
    return rec.wr && (rec.dst == src) && (rec.tnew == 2'd0);
  endfunction

  function automatic logic [1:0] pick(reg_t src, rec_t near, rec_t far);
    if (ready(src, near)) return 2'd1;
    if (ready(src, far))  return 2'd2;
    return 2'd0;
  endfunction

  function automatic rec_t age(rec_t rec);
    rec_t r = rec;
    if (r.tnew != 2'd0) r.tnew = r.tnew - 2'd1;
    return r;
  endfunction

  always_comb begin
    w_op     = ins_d[31:26];
    w_fn     = ins_d[5:0];
    w_rs     = reg_t'(ins_d[25:21]);
    w_rt     = reg_t'(ins_d[20:16]);
    w_rd     = reg_t'(ins_d[15:11]);
    w_cal_r  = 1'b0;
    w_cal_i  = 1'b0;
    w_load   = 1'b0;
    w_store  = 1'b0;
    w_branch = 1'b0;
    w_jal    = 1'b0;
    w_jr     = 1'b0;
    w_md     = 1'b0;
    w_mf     = 1'b0;
    w_mt     = 1'b0;
    w_div    = 1'b0;
    if (w_op == 6'h00) begin
      case (w_fn)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b: w_cal_r = 1'b1;
        6'h08:        w_jr = 1'b1;
        6'h18, 6'h19: w_md = 1'b1;
        6'h1a, 6'h1b: begin
          w_md  = 1'b1;
          w_div = 1'b1;
        end
        6'h10, 6'h12: w_mf = 1'b1;
        6'h11, 6'h13: w_mt = 1'b1;
        default: ;
      endcase
    end else begin
      case (w_op)
        6'h08, 6'h0c, 6'h0d, 6'h0f: w_cal_i  = 1'b1;
        6'h23, 6'h21, 6'h20:        w_load   = 1'b1;
        6'h2b, 6'h29, 6'h28:        w_store  = 1'b1;
        6'h04, 6'h05:               w_branch = 1'b1;
        6'h03:                      w_jal    = 1'b1;
        default: ;
      endcase
    end

    w_tuse_rs = (w_branch | w_jr) ? 2'd0 : 2'd1;
    w_tuse_rt = w_branch ? 2'd0 : (w_store ? 2'd2 : 2'd1);
    w_src_rs  = (w_cal_r | w_cal_i | w_load | w_store | w_branch | w_jr | w_md | w_mt) ?
                w_rs : '0;
    w_src_rt  = (w_cal_r | w_store | w_branch | w_md) ? w_rt : '0;
    w_src_st  = w_store ? w_rt : '0;

    w_rec_d = '0;
    if (w_cal_r | w_mf) begin
      w_rec_d.dst  = w_rd;
      w_rec_d.tnew = 2'd1;
    end else if (w_cal_i) begin
      w_rec_d.dst  = w_rt;
      w_rec_d.tnew = 2'd1;
    end else if (w_load) begin
      w_rec_d.dst  = w_rt;
      w_rec_d.tnew = 2'd2;
    end else if (w_jal) begin
      w_rec_d.dst  = reg_t'(31);
      w_rec_d.tnew = 2'd0;
    end
    w_rec_d.wr     = (w_rec_d.dst != '0);
    w_rec_d.md     = w_md;
    w_rec_d.md_div = w_div;
  end

  assign mdu_busy = (r_mdu_cnt != '0);

  always_comb begin
    stall = hazard(w_src_rs, w_tuse_rs, r_rec_e) | hazard(w_src_rs, w_tuse_rs, r_rec_m) |
            hazard(w_src_rt, w_tuse_rt, r_rec_e) | hazard(w_src_rt, w_tuse_rt, r_rec_m) |
            ((w_md | w_mf | w_mt) & (mdu_busy | r_rec_e.md));
    fwd_rs_d = pick(w_src_rs, r_rec_e, r_rec_m);
    fwd_rt_d = pick(w_src_rt, r_rec_e, r_rec_m);
    fwd_rs_e = pick(r_rs_e, r_rec_m, r_rec_w);
    fwd_rt_e = pick(r_rt_e, r_rec_m, r_rec_w);
    fwd_rt_m = ready(r_st_m, r_rec_w) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rec_e   <= '0;
      r_rec_m   <= '0;
      r_rec_w   <= '0;
      r_rs_e    <= '0;
      r_rt_e    <= '0;
      r_st_e    <= '0;
      r_st_m    <= '0;
      r_mdu_cnt <= '0;
    end else begin
      if (stall) begin
        r_rec_e <= '0;
        r_rs_e  <= '0;
        r_rt_e  <= '0;
        r_st_e  <= '0;
      end else begin
        r_rec_e <= w_rec_d;
        r_rs_e  <= w_src_rs;
        r_rt_e  <= w_src_rt;
        r_st_e  <= w_src_st;
      end
      r_rec_m <= age(r_rec_e);
      r_rec_w <= age(r_rec_m);
      r_st_m  <= r_st_e;
      // An md start in E loads even while D stalls behind it.
      if (r_rec_e.md) begin
        r_mdu_cnt <= r_rec_e.md_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
      end else if (r_mdu_cnt != '0) begin
        r_mdu_cnt <= r_mdu_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed sequences then random instruction
// streams, checked against an instruction-level pipeline model.
module tb_hazard_scoreboard;
  localparam int MultCycles = 5;
  localparam int DivCycles  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins_d;
  logic        stall, mdu_busy;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles),
    .REG_AW     (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ins_d   (ins_d),
    .stall   (stall),
    .fwd_rs_d(fwd_rs_d),
    .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m),
    .mdu_busy(mdu_busy)
  );

  typedef struct packed {
    logic       stall;
    logic [1:0] rs_d, rt_d, rs_e, rt_e, rt_m;
    logic       busy;
  } exp_t;
  typedef struct {
    logic [31:0] ins;
    exp_t        e;
  } item_t;
  typedef enum int {KBub, KCalR, KCalI, KLoad, KStore, KBr, KJal, KJr, KMd, KMf, KMt} kind_e;

  item_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Model state: instruction words occupying E, M, W (0 = bubble) and MDU cycles left.
  logic [31:0] m_stage[3] = '{32'h0, 32'h0, 32'h0};
  int          m_cnt = 0;

  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt);
    return {op, rs, rt, 16'h0010};
  endfunction

  function automatic kind_e kind_of(logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b: return KCalR;
        6'h08:                      return KJr;
        6'h18, 6'h19, 6'h1a, 6'h1b: return KMd;
        6'h10, 6'h12:               return KMf;
        6'h11, 6'h13:               return KMt;
        default:                    return KBub;
      endcase
    end
    case (op)
      6'h08, 6'h0c, 6'h0d, 6'h0f: return KCalI;
      6'h23, 6'h21, 6'h20:        return KLoad;
      6'h2b, 6'h29, 6'h28:        return KStore;
      6'h04, 6'h05:               return KBr;
      6'h03:                      return KJal;
      default:                    return KBub;
    endcase
  endfunction

  function automatic logic [4:0] dest(logic [31:0] i);
    case (kind_of(i))
      KCalR, KMf:   return i[15:11];
      KCalI, KLoad: return i[20:16];
      KJal:         return 5'd31;
      default:      return 5'd0;
    endcase
  endfunction

  // Cycles until the result exists, counted from entry into E.
  function automatic int tnew0(logic [31:0] i);
    case (kind_of(i))
      KLoad:   return 2;
      KJal:    return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int tuse_rs(logic [31:0] i);
    case (kind_of(i))
      KBr, KJr:                                  return 0;
      KCalR, KCalI, KLoad, KStore, KMd, KMt:     return 1;
      default:                                   return -1;
    endcase
  endfunction

  function automatic int tuse_rt(logic [31:0] i);
    case (kind_of(i))
      KBr:        return 0;
      KCalR, KMd: return 1;
      KStore:     return 2;
      default:    return -1;
    endcase
  endfunction

  // Remaining producer latency for the instruction k stages past entry into E.
  function automatic int tnew_at(int k);
    int t;
    t = tnew0(m_stage[k]) - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit writes(int k, logic [4:0] r);
    return (r != 5'd0) && (dest(m_stage[k]) == r);
  endfunction

  function automatic logic [1:0] sel(logic [4:0] r, int first, int n);
    for (int j = 0; j < n; j++) begin
      if (writes(first + j, r) && tnew_at(first + j) == 0) return 2'(j + 1);
    end
    return 2'd0;
  endfunction

  function automatic exp_t model_out(logic [31:0] d);
    exp_t  e;
    kind_e kd;
    e  = '0;
    kd = kind_of(d);
    for (int k = 0; k < 2; k++) begin
      if (tuse_rs(d) >= 0 && writes(k, d[25:21]) && tnew_at(k) > tuse_rs(d)) e.stall = 1'b1;
      if (tuse_rt(d) >= 0 && writes(k, d[20:16]) && tnew_at(k) > tuse_rt(d)) e.stall = 1'b1;
    end
    if ((kd == KMd || kd == KMf || kd == KMt) && (m_cnt > 0 || kind_of(m_stage[0]) == KMd))
      e.stall = 1'b1;
    e.rs_d = (tuse_rs(d) >= 0) ? sel(d[25:21], 0, 2) : 2'd0;
    e.rt_d = (tuse_rt(d) >= 0) ? sel(d[20:16], 0, 2) : 2'd0;
    e.rs_e = (tuse_rs(m_stage[0]) >= 0) ? sel(m_stage[0][25:21], 1, 2) : 2'd0;
    e.rt_e = (tuse_rt(m_stage[0]) >= 0) ? sel(m_stage[0][20:16], 1, 2) : 2'd0;
    e.rt_m = (kind_of(m_stage[1]) == KStore) ? sel(m_stage[1][20:16], 2, 1) : 2'd0;
    e.busy = (m_cnt != 0);
    return e;
  endfunction

  task automatic model_step(input logic [31:0] d, input logic rst, input logic stl);
    if (!rst) begin
      m_stage = '{32'h0, 32'h0, 32'h0};
      m_cnt   = 0;
    end else begin
      if (kind_of(m_stage[0]) == KMd)
        m_cnt = (m_stage[0][5:0] inside {6'h1a, 6'h1b}) ? DivCycles : MultCycles;
      else if (m_cnt > 0)
        m_cnt = m_cnt - 1;
      m_stage[2] = m_stage[1];
      m_stage[1] = m_stage[0];
      m_stage[0] = stl ? 32'h0 : d;
    end
  endtask

  task automatic issue(input logic [31:0] i, input logic rst, output logic stl);
    item_t it;
    @(posedge clk);
    #1;
    ins_d = i;
    reset = rst;
    it.ins = i;
    it.e   = model_out(i);
    exp_q.push_back(it);
    stl = it.e.stall;
    model_step(i, rst, it.e.stall);
  endtask

  // Hold an instruction in D until it is no longer stalled, as the pipeline would.
  task automatic run(input logic [31:0] i);
    logic s;
    for (int n = 0; n < 30; n++) begin
      issue(i, 1'b1, s);
      if (!s) return;
    end
    n_bad++;
    $display("FAIL hold ins=%h: still stalled after 30 cycles, required release", i);
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] calr_fn[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b};
    logic [5:0] cali_op[4] = '{6'h08, 6'h0c, 6'h0d, 6'h0f};
    logic [5:0] ld_op[3]   = '{6'h23, 6'h21, 6'h20};
    logic [5:0] st_op[3]   = '{6'h2b, 6'h29, 6'h28};
    case ($urandom_range(0, 12))
      0, 1:    return enc_r(calr_fn[$urandom_range(0, 5)], rreg(), rreg(), rreg());
      2, 3:    return enc_i(cali_op[$urandom_range(0, 3)], rreg(), rreg());
      4:       return enc_i(ld_op[$urandom_range(0, 2)], rreg(), rreg());
      5:       return enc_i(st_op[$urandom_range(0, 2)], rreg(), rreg());
      6:       return enc_i(6'($urandom_range(4, 5)), rreg(), rreg());
      7:       return {6'h03, 26'h0000100};
      8:       return enc_r(6'h08, rreg(), 5'd0, 5'd0);
      9:       return enc_r(6'($urandom_range(6'h18, 6'h1b)), rreg(), rreg(), 5'd0);
      10:      return enc_r(($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12, 5'd0, 5'd0, rreg());
      11:      return enc_r(($urandom_range(0, 1) != 0) ? 6'h11 : 6'h13, rreg(), 5'd0, 5'd0);
      default: return ($urandom_range(0, 1) != 0) ? 32'h0 : {6'h3f, 26'($urandom())};
    endcase
  endfunction

  initial begin : monitor
    item_t it;
    exp_t  got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        it  = exp_q.pop_front();
        got = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, mdu_busy};
        n_vec++;
        if (got !== it.e) begin
          n_bad++;
          $display("FAIL vec%0d ins=%h: got stall=%0b fwd_d=%0d/%0d fwd_e=%0d/%0d fwd_m=%0d busy=%0b, exp stall=%0b fwd_d=%0d/%0d fwd_e=%0d/%0d fwd_m=%0d busy=%0b",
                   n_vec, it.ins, got.stall, got.rs_d, got.rt_d, got.rs_e, got.rt_e, got.rt_m,
                   got.busy, it.e.stall, it.e.rs_d, it.e.rt_d, it.e.rs_e, it.e.rt_e,
                   it.e.rt_m, it.e.busy);
        end
      end
    end
  end

  initial begin : driver
    logic        s;
    logic [31:0] cur;
    reset = 1'b0;
    ins_d = 32'h0;
    issue(32'h0, 1'b0, s);
    issue(32'h0, 1'b0, s);
    repeat (2) issue(32'h0, 1'b1, s);

    // lw $1 -> add $2,$1,$3
    run(enc_i(6'h23, 5'd0, 5'd1));
    run(enc_r(6'h20, 5'd1, 5'd3, 5'd2));
    repeat (3) run(32'h0);
    // ori $1 -> beq $1,$0 ; jal -> jr $31
    run(enc_i(6'h0d, 5'd0, 5'd1));
    run(enc_i(6'h04, 5'd1, 5'd0));
    run({6'h03, 26'h0000100});
    run(enc_r(6'h08, 5'd31, 5'd0, 5'd0));
    repeat (3) run(32'h0);
    // lw $1 -> beq $1,$0 ; sw after add for store-data forwarding
    run(enc_i(6'h23, 5'd0, 5'd1));
    run(enc_i(6'h04, 5'd1, 5'd0));
    run(enc_r(6'h20, 5'd1, 5'd1, 5'd2));
    run(enc_i(6'h2b, 5'd0, 5'd2));
    repeat (3) run(32'h0);
    // writes to $0 are never hazards
    run(enc_r(6'h20, 5'd1, 5'd2, 5'd0));
    run(enc_r(6'h20, 5'd0, 5'd0, 5'd3));
    repeat (3) run(32'h0);
    // mult -> mflo, div -> mflo
    run(enc_r(6'h18, 5'd1, 5'd2, 5'd0));
    run(enc_r(6'h12, 5'd0, 5'd0, 5'd3));
    run(enc_r(6'h1a, 5'd1, 5'd2, 5'd0));
    run(enc_r(6'h12, 5'd0, 5'd0, 5'd3));
    repeat (2) run(32'h0);
    // div, then reset on the 3rd busy cycle while mflo waits
    issue(enc_r(6'h1b, 5'd1, 5'd2, 5'd0), 1'b1, s);
    repeat (3) issue(enc_r(6'h12, 5'd0, 5'd0, 5'd3), 1'b1, s);
    issue(enc_r(6'h12, 5'd0, 5'd0, 5'd3), 1'b0, s);
    repeat (2) issue(enc_r(6'h12, 5'd0, 5'd0, 5'd3), 1'b1, s);

    cur = rand_ins();
    for (int n = 0; n < 3000; n++) begin
      issue(cur, ($urandom_range(0, 79) != 0), s);
      if (!s) cur = rand_ins();
    end
    repeat (3) issue(32'h0, 1'b1, s);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
